// File: rtl/lc3b_mem_arbiter.sv
// ---------------------------------------------------------------------------
// lc3b_mem_arbiter
//
// Shares the single physical-memory line port between the I-cache and the
// D-cache miss/writeback engines. One line transaction is in flight at a
// time. The D-cache has priority, but after D_STREAK_MAX consecutive D grants
// made while the I-cache was waiting, the next grant goes to the I-cache.
//
// Ports:
//   clk, rst_n                  clock, synchronous active-low reset
//   i_pmem_read/address         I-cache line-read request
//   i_pmem_rdata/resp           line data / completion back to I-cache
//   d_pmem_read/write/address   D-cache line-read or writeback request
//   d_pmem_wdata                D-cache writeback line
//   d_pmem_rdata/resp           line data / completion back to D-cache
//   pmem_read/write             registered memory strobes, held until resp
//   pmem_address/wdata          registered address / write line
//   pmem_rdata/resp             memory read line and completion pulse
//   busy                        high while a transaction is being served
// ---------------------------------------------------------------------------
module lc3b_mem_arbiter #(
    parameter int ADDR_W       = 16,
    parameter int LINE_W       = 128,
    parameter int D_STREAK_MAX = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_pmem_read,
    input  logic [ADDR_W-1:0] i_pmem_address,
    output logic [LINE_W-1:0] i_pmem_rdata,
    output logic              i_pmem_resp,
    input  logic              d_pmem_read,
    input  logic              d_pmem_write,
    input  logic [ADDR_W-1:0] d_pmem_address,
    input  logic [LINE_W-1:0] d_pmem_wdata,
    output logic [LINE_W-1:0] d_pmem_rdata,
    output logic              d_pmem_resp,
    output logic              pmem_read,
    output logic              pmem_write,
    output logic [ADDR_W-1:0] pmem_address,
    output logic [LINE_W-1:0] pmem_wdata,
    input  logic [LINE_W-1:0] pmem_rdata,
    input  logic              pmem_resp,
    output logic              busy
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SERVE_I = 2'd1,
        SERVE_D = 2'd2
    } state_e;

    localparam logic [3:0] STREAK_MAX = 4'(D_STREAK_MAX);

    state_e            state_q, state_d;
    logic [3:0]        d_streak_q, d_streak_d;
    logic              pmem_read_q, pmem_read_d;
    logic              pmem_write_q, pmem_write_d;
    logic [ADDR_W-1:0] pmem_address_q, pmem_address_d;
    logic [LINE_W-1:0] pmem_wdata_q, pmem_wdata_d;

    logic d_req, i_req, streak_full, grant_d, grant_i;

    assign d_req       = d_pmem_read | d_pmem_write;
    assign i_req       = i_pmem_read;
    assign streak_full = (d_streak_q == STREAK_MAX);
    // D wins unless it has already starved a waiting I for a full streak.
    assign grant_d     = (state_q == IDLE) && d_req && !(i_req && streak_full);
    assign grant_i     = (state_q == IDLE) && i_req && !grant_d;

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q        <= IDLE;
            d_streak_q     <= '0;
            pmem_read_q    <= 1'b0;
            pmem_write_q   <= 1'b0;
            pmem_address_q <= '0;
            pmem_wdata_q   <= '0;
        end else begin
            state_q        <= state_d;
            d_streak_q     <= d_streak_d;
            pmem_read_q    <= pmem_read_d;
            pmem_write_q   <= pmem_write_d;
            pmem_address_q <= pmem_address_d;
            pmem_wdata_q   <= pmem_wdata_d;
        end
    end

    // Next-state and latched-request logic
    always_comb begin
        state_d        = state_q;
        d_streak_d     = d_streak_q;
        pmem_read_d    = pmem_read_q;
        pmem_write_d   = pmem_write_q;
        pmem_address_d = pmem_address_q;
        pmem_wdata_d   = pmem_wdata_q;
        case (state_q)
            IDLE: begin
                if (grant_i) begin
                    state_d        = SERVE_I;
                    d_streak_d     = '0;
                    pmem_read_d    = 1'b1;
                    pmem_write_d   = 1'b0;
                    pmem_address_d = i_pmem_address;
                end else if (grant_d) begin
                    state_d        = SERVE_D;
                    // A writeback beats a simultaneous read request.
                    pmem_write_d   = d_pmem_write;
                    pmem_read_d    = !d_pmem_write;
                    pmem_address_d = d_pmem_address;
                    pmem_wdata_d   = d_pmem_wdata;
                    if (i_req && !streak_full)
                        d_streak_d = d_streak_q + 4'd1;
                end
                // The streak only measures how long I has been kept waiting.
                if (!i_req)
                    d_streak_d = '0;
            end
            SERVE_I, SERVE_D: begin
                if (pmem_resp) begin
                    state_d      = IDLE;
                    pmem_read_d  = 1'b0;
                    pmem_write_d = 1'b0;
                end
            end
            default: begin
                state_d      = IDLE;
                pmem_read_d  = 1'b0;
                pmem_write_d = 1'b0;
            end
        endcase
    end

    // Outputs: completion is forwarded combinationally to the granted side only.
    always_comb begin
        i_pmem_resp = 1'b0;
        d_pmem_resp = 1'b0;
        busy        = 1'b0;
        case (state_q)
            SERVE_I: begin
                busy        = 1'b1;
                i_pmem_resp = pmem_resp;
            end
            SERVE_D: begin
                busy        = 1'b1;
                d_pmem_resp = pmem_resp;
            end
            default: ;
        endcase
    end

    assign i_pmem_rdata = pmem_rdata;
    assign d_pmem_rdata = pmem_rdata;
    assign pmem_read    = pmem_read_q;
    assign pmem_write   = pmem_write_q;
    assign pmem_address = pmem_address_q;
    assign pmem_wdata   = pmem_wdata_q;

endmodule
